// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: substitutes COLS_PER_CYCLE 32-bit columns per clock
// through an arithmetic S-box (GF(2^8) inverse + affine), then holds the result.
module sub_bytes_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ostate,
    output logic         busy
);

    localparam int NUM_SBOX = 4 * COLS_PER_CYCLE;
    localparam int SEL_W    = 32 * COLS_PER_CYCLE;
    localparam int LAST_CNT = 4 - COLS_PER_CYCLE;
    localparam logic [127:0] SEL_MASK = ~({128{1'b1}} >> SEL_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t           r_fsm;
    logic [1:0]     r_col_cnt;
    logic [127:0]   r_state;
    logic [127:0]   r_ostate;
    logic           r_out_valid;

    logic [6:0]       w_base;
    logic [6:0]       w_shift;
    logic [SEL_W-1:0] w_cols;
    logic [SEL_W-1:0] w_sub;
    logic [127:0]     w_ins;
    logic [127:0]     w_mask;
    logic [127:0]     w_ostate_next;
    logic             w_last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 = x^-1; six square-and-multiply steps reach x^127, one final square.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can form.
    always_comb begin
        w_shift = {r_col_cnt, 5'b00000};
        w_base  = 7'd127 - w_shift;
        w_cols  = r_state[w_base -: SEL_W];
        w_sub   = '0;
        for (int j = 0; j < NUM_SBOX; j++) begin
            w_sub[SEL_W-1-8*j -: 8] = sbox(w_cols[SEL_W-1-8*j -: 8]);
        end
        w_ins         = (128'(w_sub) << (128 - SEL_W)) >> w_shift;
        w_mask        = SEL_MASK >> w_shift;
        w_ostate_next = (r_ostate & ~w_mask) | w_ins;
        w_last        = (r_col_cnt == 2'(LAST_CNT));
    end

    // NOTE: state and datapath registers use non-blocking assignments and are all reset,
    // so an aborted block never leaves a visible partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_col_cnt   <= 2'd0;
            r_state     <= '0;
            r_ostate    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= state;
                        r_col_cnt <= 2'd0;
                        r_fsm     <= BUSY;
                    end
                end
                BUSY: begin
                    r_ostate  <= w_ostate_next;
                    r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
                    if (w_last) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_out_valid;
    assign ostate    = r_ostate;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: table vectors, scoreboard on the COLS_PER_CYCLE=1 instance,
// latency comparison across 1/2/4 columns per cycle, backpressure and reset corner cases.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_i;

    logic         in_ready1, out_valid1, busy1;
    logic         in_ready2, out_valid2, busy2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] ostate1, ostate2, ostate4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[4];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] SPOT_IN  = 128'h000153ff_10000153_ff100001_53ff1000;
    localparam logic [127:0] SPOT_OUT = 128'h637ced16_ca637ced_16ca637c_ed16ca63;

    sub_bytes_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .state(state_i), .out_valid(out_valid1), .out_ready(out_ready),
        .ostate(ostate1), .busy(busy1)
    );

    sub_bytes_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .state(state_i), .out_valid(out_valid2), .out_ready(out_ready),
        .ostate(ostate2), .busy(busy2)
    );

    sub_bytes_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .state(state_i), .out_valid(out_valid4), .out_ready(out_ready),
        .ostate(ostate4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: carry-less product reduced by 0x11B, inverse by exhaustive search.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        return r;
    endfunction

    function automatic logic [127:0] m_state(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = m_sbox(s[8*b +: 8]);
        return r;
    endfunction

    // Scoreboard on the single-column instance: push on accept, pop on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready1) exp_q.push_back(m_state(state_i));
            if (out_valid1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got %h with no expected block queued", ostate1);
                end else begin
                    check("sb_result", ostate1, exp_q.pop_front());
                end
            end
        end
    end

    // Drives one block, returns the result and clocks from accept to out_valid.
    task automatic run_block(input logic [127:0] s, output logic [127:0] got, output int lat);
        int w;
        w = 0;
        while (!in_ready1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        state_i  = s;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = ostate1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        int           lat;
        int           l1, l2, l4;
        int           w;
        int           acc[3];
        logic [127:0] btb[3];

        vecs[0] = '{st: 128'h0, exp: {16{8'h63}}};
        vecs[1] = '{st: FIPS_IN, exp: FIPS_OUT};
        vecs[2] = '{st: SPOT_IN, exp: SPOT_OUT};
        vecs[3] = '{st: {16{8'hff}}, exp: {16{8'h16}}};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_i   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ostate", ostate1, 128'h0);
        check("rst_ov_busy", {126'h0, out_valid1, busy1}, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready1), 128'h1);
        @(posedge clk); #1;

        // Table vectors on the single-column instance.
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].st, got, lat);
            check($sformatf("vec%0d_ostate", i), got, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
        end

        // FIPS vector through all three widths at once.
        state_i   = FIPS_IN;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l1 = 0; l2 = 0; l4 = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (out_valid1 && l1 == 0) l1 = k;
            if (out_valid2 && l2 == 0) l2 = k;
            if (out_valid4 && l4 == 0) l4 = k;
        end
        check("lat_cpc1", 128'(l1), 128'd4);
        check("lat_cpc2", 128'(l2), 128'd2);
        check("lat_cpc4", 128'(l4), 128'd1);
        check("fips_cpc1", ostate1, FIPS_OUT);
        check("fips_cpc2", ostate2, FIPS_OUT);
        check("fips_cpc4", ostate4, FIPS_OUT);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Random blocks, checked by the scoreboard only.
        for (int i = 0; i < 4; i++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, got, lat);
        end

        // Backpressure: result held, input side closed, in_valid pulses ignored.
        state_i   = FIPS_IN;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            state_i  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", k), {in_ready1, out_valid1, ostate1[125:0]},
                  {1'b0, 1'b1, FIPS_OUT[125:0]});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {126'h0, out_valid1, in_ready1}, 128'h1);

        // Reset after two of four column cycles.
        state_i  = SPOT_IN;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ostate", ostate1, 128'h0);
        check("midrst_ov_busy", {126'h0, out_valid1, busy1}, 128'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 128'(in_ready1), 128'h1);
        run_block(SPOT_IN, got, lat);
        check("midrst_fresh", got, SPOT_OUT);

        // Back-to-back with both handshakes held high.
        btb[0] = FIPS_IN;
        btb[1] = SPOT_IN;
        btb[2] = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            state_i = btb[b];
            w = 0;
            @(negedge clk);
            while (!in_ready1 && w < 30) begin
                @(negedge clk);
                w++;
            end
            acc[b] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("btb_gap01", 128'(acc[1] - acc[0]), 128'd6);
        check("btb_gap12", 128'(acc[2] - acc[1]), 128'd6);
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        check("sb_drained", 128'(exp_q.size()), 128'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
